// File: rtl/tcp_tx_ctrl.sv
// tcp_tx_ctrl: executes SYN/ACK/FIN commands into TCP header descriptors.
// Optional: define TCP_TX_ISN_LFSR_EN to take the ISN from a free-running LFSR.

package tcp_pkg;
    typedef enum logic [1:0] {
        TX_NOP = 2'd0,
        TX_SYN = 2'd1,
        TX_ACK = 2'd2,
        TX_FIN = 2'd3
    } tx_ctrl_t;
endpackage

module tcp_tx_ctrl
    import tcp_pkg::*;
#(
    parameter logic [31:0] ISN        = 32'h0000_1000,
    parameter logic [15:0] RCV_WINDOW = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  tx_ctrl_t    i_tx_ctrl,
    input  logic        i_tx_ctrl_valid,
    output logic        o_tx_ctrl_ack,
    input  logic [31:0] i_rcv_nxt,
    input  logic        i_rcv_nxt_valid,
    output logic [7:0]  o_hdr_flags,
    output logic [31:0] o_hdr_seq,
    output logic [31:0] o_hdr_ack,
    output logic [15:0] o_hdr_window,
    output logic        o_hdr_valid,
    input  logic        i_hdr_ready,
    output logic        o_busy,
    output logic [15:0] o_seg_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_snd_nxt;
    logic [31:0] r_rcv_nxt;
    logic [7:0]  r_hdr_flags;
    logic [31:0] r_hdr_seq;
    logic [31:0] r_hdr_ack;
    logic [15:0] r_hdr_window;
    logic [15:0] r_seg_count;
    logic        w_accept;
    logic        w_hdr_cmd;
    logic        w_xfer;
    logic [31:0] w_rcv_cur;
    logic [31:0] w_isn_cur;

`ifdef TCP_TX_ISN_LFSR_EN
    // A zero seed would lock the LFSR, so fall back to 1.
    localparam logic [31:0] LFSR_SEED = (ISN == 32'd0) ? 32'd1 : ISN;
    logic [31:0] r_lfsr;

    // Galois LFSR, taps 32,22,2,1, advancing every cycle
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'd0);
    end

    assign w_isn_cur = r_lfsr;
`else
    assign w_isn_cur = ISN;
`endif

    assign w_accept  = (r_state == S_IDLE) && i_tx_ctrl_valid && i_enable;
    assign w_hdr_cmd = w_accept && (i_tx_ctrl != TX_NOP);
    assign w_xfer    = (r_state == S_HOLD) && i_hdr_ready && i_enable;
    assign w_rcv_cur = i_rcv_nxt_valid ? i_rcv_nxt : r_rcv_nxt;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; disable forces IDLE
    always_comb begin
        w_next = r_state;
        if (!i_enable) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_hdr_cmd) w_next = S_HOLD;
                S_HOLD:  if (w_xfer) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_tx_ctrl_ack = w_accept;
        o_hdr_valid   = (r_state == S_HOLD);
        o_busy        = (r_state != S_IDLE);
    end

    // Descriptor capture on accept; held stable through HOLD
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hdr_flags  <= 8'd0;
            r_hdr_seq    <= 32'd0;
            r_hdr_ack    <= 32'd0;
            r_hdr_window <= 16'd0;
        end else if (w_hdr_cmd) begin
            r_hdr_window <= RCV_WINDOW;
            unique case (i_tx_ctrl)
                TX_SYN: begin
                    r_hdr_flags <= 8'h02;
                    r_hdr_seq   <= w_isn_cur;
                    r_hdr_ack   <= 32'd0;
                end
                TX_FIN: begin
                    r_hdr_flags <= 8'h11;
                    r_hdr_seq   <= r_snd_nxt;
                    r_hdr_ack   <= w_rcv_cur;
                end
                default: begin
                    r_hdr_flags <= 8'h10;
                    r_hdr_seq   <= r_snd_nxt;
                    r_hdr_ack   <= w_rcv_cur;
                end
            endcase
        end
    end

    // Local send sequence: SYN and FIN each consume one number
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_snd_nxt <= ISN;
        else if (!i_enable)
            r_snd_nxt <= w_isn_cur;
        else if (w_hdr_cmd && i_tx_ctrl == TX_SYN)
            r_snd_nxt <= w_isn_cur + 32'd1;
        else if (w_hdr_cmd && i_tx_ctrl == TX_FIN)
            r_snd_nxt <= r_snd_nxt + 32'd1;
    end

    // Remote receive-next, loadable in any state
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable)
            r_rcv_nxt <= 32'd0;
        else if (i_rcv_nxt_valid)
            r_rcv_nxt <= i_rcv_nxt;
    end

    // Transferred-descriptor counter, survives disable
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_seg_count <= 16'd0;
        else if (w_xfer)
            r_seg_count <= r_seg_count + 16'd1;
    end

    assign o_hdr_flags  = r_hdr_flags;
    assign o_hdr_seq    = r_hdr_seq;
    assign o_hdr_ack    = r_hdr_ack;
    assign o_hdr_window = r_hdr_window;
    assign o_seg_count  = r_seg_count;

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// Scoreboard bench for tcp_tx_ctrl: expected descriptors are queued at
// command accept and compared as each descriptor transfers.

module tb_tcp_tx_ctrl;
    import tcp_pkg::*;

    typedef struct {
        logic [7:0]  f;
        logic [31:0] s;
        logic [31:0] a;
        logic [15:0] w;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        en = 1;
    tx_ctrl_t    cmd = TX_NOP;
    logic        cv = 0;
    logic [31:0] rcv = 0;
    logic        rcv_valid = 0;
    logic        ready = 0;
    logic        use2 = 0;

    logic        a1, a2, hv1, hv2, b1, b2;
    logic [7:0]  f1, f2;
    logic [31:0] s1, s2, k1, k2;
    logic [15:0] w1, w2, c1, c2;

    logic        w_ack, w_hv, w_busy;
    logic [7:0]  w_f;
    logic [31:0] w_s, w_a;
    logic [15:0] w_w, w_c;

    exp_t        q[$];
    logic [31:0] m_isn = 32'h0000_1000;
    logic [31:0] m_snd;
    logic [31:0] m_rcv;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    tcp_tx_ctrl u_dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_tx_ctrl(cmd), .i_tx_ctrl_valid(cv), .o_tx_ctrl_ack(a1),
        .i_rcv_nxt(rcv), .i_rcv_nxt_valid(rcv_valid),
        .o_hdr_flags(f1), .o_hdr_seq(s1), .o_hdr_ack(k1),
        .o_hdr_window(w1), .o_hdr_valid(hv1), .i_hdr_ready(ready),
        .o_busy(b1), .o_seg_count(c1)
    );

    tcp_tx_ctrl #(.ISN(32'hFFFF_FFFF)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_tx_ctrl(cmd), .i_tx_ctrl_valid(cv), .o_tx_ctrl_ack(a2),
        .i_rcv_nxt(rcv), .i_rcv_nxt_valid(rcv_valid),
        .o_hdr_flags(f2), .o_hdr_seq(s2), .o_hdr_ack(k2),
        .o_hdr_window(w2), .o_hdr_valid(hv2), .i_hdr_ready(ready),
        .o_busy(b2), .o_seg_count(c2)
    );

    assign w_ack  = use2 ? a2 : a1;
    assign w_hv   = use2 ? hv2 : hv1;
    assign w_busy = use2 ? b2 : b1;
    assign w_f    = use2 ? f2 : f1;
    assign w_s    = use2 ? s2 : s1;
    assign w_a    = use2 ? k2 : k1;
    assign w_w    = use2 ? w2 : w1;
    assign w_c    = use2 ? c2 : c1;

    // Scoreboard: compare each descriptor as it transfers
    always @(negedge clk) begin
        exp_t e;
        if (!rst && en && w_hv && ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_desc got f=%h s=%h a=%h, required none",
                         w_f, w_s, w_a);
            end else begin
                e = q.pop_front();
                if (w_f !== e.f || w_s !== e.s || w_a !== e.a || w_w !== e.w) begin
                    fails++;
                    $display("FAIL desc got f=%h s=%h a=%h w=%0d, required f=%h s=%h a=%h w=%0d",
                             w_f, w_s, w_a, w_w, e.f, e.s, e.a, e.w);
                end
            end
        end
    end

    // Reference model of one accepted command
    function automatic void model(input tx_ctrl_t c, input logic rv,
                                  input logic [31:0] rd);
        logic [31:0] r;
        exp_t e;
        r = rv ? rd : m_rcv;
        e.w = 16'd1024;
        case (c)
            TX_SYN: begin
                e.f = 8'h02; e.s = m_isn; e.a = 0;
                m_snd = m_isn + 1; q.push_back(e);
            end
            TX_ACK: begin
                e.f = 8'h10; e.s = m_snd; e.a = r; q.push_back(e);
            end
            TX_FIN: begin
                e.f = 8'h11; e.s = m_snd; e.a = r;
                m_snd = m_snd + 1; q.push_back(e);
            end
            default: ;
        endcase
        if (rv) m_rcv = rd;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; cv = 0; rcv_valid = 0; en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_snd = m_isn; m_rcv = 0;
        q.delete();
    endtask

    task automatic issue(input tx_ctrl_t c, input logic rv,
                         input logic [31:0] rd);
        int n;
        logic got;
        @(posedge clk); #1;
        cmd = c; cv = 1; rcv_valid = rv; rcv = rd;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (w_ack === 1'b1) got = 1;
            else begin
                if (rv) m_rcv = rd;
                n++;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL cmd_ack_timeout got no ack in 20 cycles, required ack");
        end else begin
            model(c, rv, rd);
        end
        @(posedge clk); #1;
        cv = 0; rcv_valid = 0;
    endtask

    task automatic load_rcv(input logic [31:0] v);
        @(posedge clk); #1;
        rcv = v; rcv_valid = 1;
        @(posedge clk); #1;
        rcv_valid = 0;
        m_rcv = v;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending, required 0", q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if (w_ack !== 0 || w_hv !== 0 || w_busy !== 0 || w_c !== 0) begin
            fails++;
            $display("FAIL reset_ctrl got ack=%b v=%b busy=%b cnt=%0d, required 0 0 0 0",
                     w_ack, w_hv, w_busy, w_c);
        end
        tests++;
        if (w_f !== 0 || w_s !== 0 || w_a !== 0 || w_w !== 0) begin
            fails++;
            $display("FAIL reset_hdr got f=%h s=%h a=%h w=%h, required all 0",
                     w_f, w_s, w_a, w_w);
        end
    endtask

    task automatic test_syn();
        ready = 1;
        issue(TX_SYN, 0, 0);
        @(negedge clk);
        tests++;
        if (w_hv !== 1'b1) begin
            fails++;
            $display("FAIL syn_latency got valid=%b, required 1", w_hv);
        end
        drain();
        @(negedge clk);
        tests++;
        if (w_c !== 16'd1) begin
            fails++;
            $display("FAIL syn_count got %0d, required 1", w_c);
        end
    endtask

    task automatic test_ack();
        load_rcv(32'h5000_0001);
        issue(TX_ACK, 0, 0);
        issue(TX_ACK, 0, 0);
        drain();
        @(negedge clk);
        tests++;
        if (w_c !== 16'd3) begin
            fails++;
            $display("FAIL ack_count got %0d, required 3", w_c);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 0;
        issue(TX_SYN, 0, 0);
        cmd = TX_FIN; cv = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (w_ack !== 0 || w_hv !== 1 || w_f !== 8'h02 || w_s !== m_isn) begin
                fails++;
                $display("FAIL hold_stable got ack=%b v=%b f=%h s=%h, required 0 1 02 %h",
                         w_ack, w_hv, w_f, w_s, m_isn);
            end
        end
        @(posedge clk); #1;
        ready = 1;
        @(negedge clk);
        tests++;
        if (w_ack !== 1'b0) begin
            fails++;
            $display("FAIL fin_early_ack got %b, required 0", w_ack);
        end
        @(negedge clk);
        tests++;
        if (w_ack !== 1'b1) begin
            fails++;
            $display("FAIL fin_first_idle_ack got %b, required 1", w_ack);
        end else begin
            model(TX_FIN, 0, 0);
        end
        @(posedge clk); #1;
        cv = 0;
        drain();
    endtask

    task automatic test_wrap();
        use2 = 1;
        m_isn = 32'hFFFF_FFFF;
        do_reset();
        ready = 1;
        issue(TX_SYN, 0, 0);
        issue(TX_FIN, 0, 0);
        issue(TX_ACK, 0, 0);
        drain();
        use2 = 0;
        m_isn = 32'h0000_1000;
        do_reset();
    endtask

    task automatic test_enable();
        logic [15:0] c0;
        ready = 1;
        issue(TX_SYN, 0, 0);
        drain();
        load_rcv(32'h0000_1234);
        ready = 0;
        issue(TX_ACK, 0, 0);
        @(negedge clk);
        c0 = w_c;
        @(posedge clk); #1;
        en = 0; cmd = TX_ACK; cv = 1;
        @(negedge clk);
        tests++;
        if (w_ack !== 1'b0) begin
            fails++;
            $display("FAIL disabled_ack got %b, required 0", w_ack);
        end
        @(posedge clk); #1;
        en = 1; cv = 0;
        @(negedge clk);
        tests++;
        if (w_hv !== 1'b0 || w_c !== c0) begin
            fails++;
            $display("FAIL disable_drop got v=%b cnt=%0d, required 0 %0d",
                     w_hv, w_c, c0);
        end
        void'(q.pop_back());
        m_snd = m_isn; m_rcv = 0;
        ready = 1;
        issue(TX_ACK, 0, 0);
        drain();
    endtask

    task automatic test_bypass_nop();
        logic [15:0] c0;
        ready = 1;
        load_rcv(32'h0000_7777);
        issue(TX_ACK, 1, 32'hDEAD_BEEF);
        drain();
        @(negedge clk);
        c0 = w_c;
        issue(TX_NOP, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (w_hv !== 1'b0 || w_busy !== 1'b0 || w_c !== c0) begin
                fails++;
                $display("FAIL nop_no_desc got v=%b busy=%b cnt=%0d, required 0 0 %0d",
                         w_hv, w_busy, w_c, c0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] c0;
        ready = 1;
        @(negedge clk);
        c0 = w_c;
        n = 0;
        @(posedge clk); #1;
        cmd = TX_ACK; cv = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (w_ack === 1'b1) begin
                model(TX_ACK, 0, 0);
                n++;
            end
        end
        @(posedge clk); #1;
        cv = 0;
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL b2b_rate got %0d acks, required 4", n);
        end
        drain();
        @(negedge clk);
        tests++;
        if (w_c !== c0 + 16'd4) begin
            fails++;
            $display("FAIL b2b_count got %0d, required %0d", w_c, c0 + 16'd4);
        end
    endtask

    initial begin
        test_reset();
        test_syn();
        test_ack();
        test_backpressure();
        test_wrap();
        test_enable();
        test_bypass_nop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tcp_tx_ctrl.md
# tcp_tx_ctrl

Transmit-side command executor for the network processor's TCP engine. Consumes `tx_ctrl_t` commands (NOP/SEND_SYN/SEND_ACK/SEND_FIN) from the TCP state manager, tracks local send sequence and remote receive-next numbers, and emits one TCP header descriptor per command to the segment builder over a valid/ready stream. It is the execution end of the state manager's tx_ctrl handshake.

## Interface
- `ISN`, 32'h0000_1000, initial send sequence number
- `RCV_WINDOW`, 16'd1024, advertised window placed in every header
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_enable`  in  1  low forces IDLE and clears sequence state
- `i_tx_ctrl`  in  tcp_pkg::tx_ctrl_t  command
- `i_tx_ctrl_valid`  in  1  command present
- `o_tx_ctrl_ack`  out  1  command accepted this cycle (combinational)
- `i_rcv_nxt`  in  32  next expected remote sequence number, from rx parser
- `i_rcv_nxt_valid`  in  1  load `i_rcv_nxt`
- `o_hdr_flags`  out  8  TCP flags: bit0 FIN, bit1 SYN, bit2 RST, bit3 PSH, bit4 ACK
- `o_hdr_seq`  out  32  sequence number field
- `o_hdr_ack`  out  32  acknowledgment number field
- `o_hdr_window`  out  16  window field
- `o_hdr_valid`  out  1  descriptor valid
- `i_hdr_ready`  in  1  segment builder accepts descriptor
- `o_busy`  out  1  state != IDLE
- `o_seg_count`  out  16  descriptors transferred, wraps at 2^16

## Operation
- States: IDLE, HOLD.
- IDLE: `o_tx_ctrl_ack = i_tx_ctrl_valid`. NOP: acked, no descriptor, stay IDLE. SYN/ACK/FIN: acked, descriptor registered, go HOLD.
- HOLD: `o_hdr_valid=1`, descriptor stable; `o_tx_ctrl_ack=0` regardless of valid. On `o_hdr_valid && i_hdr_ready`: `o_seg_count+1`, go IDLE.
- Descriptor build at accept (snd_nxt/rcv_nxt = values before this cycle's update):
  - SYN: flags 8'h02, seq=ISN, ack=0, snd_nxt <= ISN+1.
  - ACK: flags 8'h10, seq=snd_nxt, ack=rcv_nxt, snd_nxt unchanged.
  - FIN: flags 8'h11, seq=snd_nxt, ack=rcv_nxt, snd_nxt <= snd_nxt+1.
- window always RCV_WINDOW. All sequence arithmetic modulo 2^32.
- rcv_nxt loaded whenever `i_rcv_nxt_valid`, any state. Load coincident with ACK/FIN accept: descriptor uses new `i_rcv_nxt` (bypass).
- Commands arriving while HOLD are not acked; upstream holds valid or reissues.
- `i_enable` low: next cycle IDLE, `o_hdr_valid=0`, pending descriptor dropped (not counted), snd_nxt=ISN, rcv_nxt=0. Commands not acked while disabled. `o_seg_count` retained.

## Timing
- Reset values: `o_tx_ctrl_ack` 0 (no valid), `o_hdr_*` 0, `o_hdr_valid` 0, `o_busy` 0, `o_seg_count` 0; snd_nxt=ISN, rcv_nxt=0.
- Accept at cycle T -> `o_hdr_valid` high T+1. Ready high at T+1 -> transfer T+1, IDLE T+2, next accept T+2 earliest. Max rate 1 descriptor / 2 cycles.
- `o_hdr_*` change only on accept cycle edge; stable throughout HOLD.
- `i_rst` dominates `i_enable`.

## Configuration
- `TCP_TX_ISN_LFSR_EN` defined: 32-bit Galois LFSR (taps 32,22,2,1, seed ISN, nonzero) advances every cycle; SYN samples LFSR value as seq and sets snd_nxt=sample+1; enable-low reload uses sample too. Undefined: SYN uses parameter ISN, no LFSR logic.

## Test plan
- Reset, ISN=32'h0000_1000, SYN with ready=1 -> T+1 flags 8'h02, seq 32'h0000_1000, ack 0, window 1024; `o_seg_count`=1.
- Load rcv_nxt 32'h5000_0001, then ACK -> flags 8'h10, seq 32'h0000_1001, ack 32'h5000_0001; snd_nxt stays 32'h0000_1001.
- SYN with ready low 5 cycles while FIN held valid -> descriptor stable, FIN ack=0 until transfer; FIN acked first IDLE cycle, seq 32'h0000_1001.
- ISN=32'hFFFF_FFFF: SYN then FIN -> FIN seq 32'h0000_0000, snd_nxt wraps to 32'h0000_0001.
- Enable low during HOLD -> `o_hdr_valid` 0 next cycle, count unchanged, subsequent ACK uses seq=ISN, ack=0.
- `i_rcv_nxt_valid` with 32'hDEAD_BEEF same cycle as ACK accept -> ack field 32'hDEAD_BEEF; NOP -> acked, no `o_hdr_valid`.
